// File: rtl/pic_sched_pkg.sv
// rtl/pic_sched_pkg.sv - shared encodings and default window positions for pic_window_sched
package pic_sched_pkg;

  typedef enum logic [1:0] {
    WS_BG = 2'b00,
    WS_W0 = 2'b01,
    WS_W1 = 2'b10
  } win_sel_t;

  typedef enum logic {
    WAIT_VS = 1'b0,
    RUN     = 1'b1
  } state_t;

  localparam int DEF_X0 = 640;
  localparam int DEF_Y0 = 412;
  localparam int DEF_X1 = 1024;
  localparam int DEF_Y1 = 412;

endpackage

// File: rtl/win_hit.sv
// rtl/win_hit.sv - look-ahead range comparator for one picture window
module win_hit #(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12,
  parameter int PIC_W  = 256,
  parameter int PIC_H  = 256,
  parameter int LEAD   = 5
) (
  input  logic [X_BITS-1:0] x,
  input  logic [Y_BITS-1:0] y,
  input  logic [X_BITS-1:0] win_x,
  input  logic [Y_BITS-1:0] win_y,
  output logic              hit
);

  // One extra bit keeps x+LEAD and win+PIC_W from wrapping near the screen edge
  logic [X_BITS:0] x_ahead, x_lo, x_hi;
  logic [Y_BITS:0] y_ext, y_lo, y_hi;

  always_comb begin
    x_ahead = {1'b0, x} + (X_BITS+1)'(LEAD);
    x_lo    = {1'b0, win_x};
    x_hi    = x_lo + (X_BITS+1)'(PIC_W);
    y_ext   = {1'b0, y};
    y_lo    = {1'b0, win_y};
    y_hi    = y_lo + (Y_BITS+1)'(PIC_H);
    hit     = (x_ahead >= x_lo) && (x_ahead < x_hi) && (y_ext >= y_lo) && (y_ext < y_hi);
  end

endmodule

// File: rtl/pic_window_sched.sv
// rtl/pic_window_sched.sv - two-window ROM read scheduler with delay-aligned window-select tag
module pic_window_sched
  import pic_sched_pkg::*;
#(
  parameter int   X_BITS    = 12,
  parameter int   Y_BITS    = 12,
  parameter int   ADDR_BITS = 16,
  parameter int   PIC_W     = 256,
  parameter int   PIC_H     = 256,
  parameter int   LEAD      = 5,
  parameter logic VS_POL    = 1'b1,
  parameter int   X0        = DEF_X0,
  parameter int   Y0        = DEF_Y0,
  parameter int   X1        = DEF_X1,
  parameter int   Y1        = DEF_Y1
) (
  input  logic                 pix_clk,
  input  logic                 rst,
  input  logic [X_BITS-1:0]    act_x,
  input  logic [Y_BITS-1:0]    act_y,
  input  logic                 vs_in,
  input  logic                 cfg_valid,
  input  logic                 cfg_win,
  input  logic [X_BITS-1:0]    cfg_x,
  input  logic [Y_BITS-1:0]    cfg_y,
  output logic                 cfg_ready,
  output logic [ADDR_BITS-1:0] rom_addr,
  output logic                 rom_en,
  output logic [1:0]           win_sel_out,
  output logic                 cfg_pending
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(PIC_W * PIC_H - 1);

  state_t                state;
  logic                  vs_d;
  logic [ADDR_BITS-1:0]  cnt0, cnt1;
  logic [X_BITS-1:0]     x0_q, x1_q, pend_x;
  logic [Y_BITS-1:0]     y0_q, y1_q, pend_y;
  logic                  pend_win;
  win_sel_t              tag_pipe [LEAD];
  win_sel_t              tag_in;
  logic                  hit0, hit1, frame_start, accept;

  win_hit #(.X_BITS(X_BITS), .Y_BITS(Y_BITS), .PIC_W(PIC_W), .PIC_H(PIC_H), .LEAD(LEAD)) u_hit0 (
    .x(act_x), .y(act_y), .win_x(x0_q), .win_y(y0_q), .hit(hit0)
  );

  win_hit #(.X_BITS(X_BITS), .Y_BITS(Y_BITS), .PIC_W(PIC_W), .PIC_H(PIC_H), .LEAD(LEAD)) u_hit1 (
    .x(act_x), .y(act_y), .win_x(x1_q), .win_y(y1_q), .hit(hit1)
  );

  assign frame_start = (vs_in == VS_POL) && (vs_d != VS_POL);
  assign accept      = cfg_valid && !cfg_pending;
  assign cfg_ready   = !cfg_pending;
  assign win_sel_out = tag_pipe[LEAD-1];
  assign tag_in      = hit0 ? WS_W0 : (hit1 ? WS_W1 : WS_BG);

  function automatic logic [ADDR_BITS-1:0] next_cnt(input logic [ADDR_BITS-1:0] c);
    return (c == LAST_ADDR) ? '0 : c + 1'b1;
  endfunction

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_VS;
      vs_d        <= !VS_POL;
      cnt0        <= '0;
      cnt1        <= '0;
      x0_q        <= X_BITS'(X0);
      y0_q        <= Y_BITS'(Y0);
      x1_q        <= X_BITS'(X1);
      y1_q        <= Y_BITS'(Y1);
      pend_win    <= 1'b0;
      pend_x      <= '0;
      pend_y      <= '0;
      cfg_pending <= 1'b0;
      rom_addr    <= '0;
      rom_en      <= 1'b0;
      for (int i = 0; i < LEAD; i++) tag_pipe[i] <= WS_BG;
    end else begin
      vs_d <= vs_in;
      for (int i = 1; i < LEAD; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (accept) begin
        pend_win <= cfg_win;
        pend_x   <= cfg_x;
        pend_y   <= cfg_y;
      end
      if (frame_start) begin
        state       <= RUN;
        cnt0        <= '0;
        cnt1        <= '0;
        rom_en      <= 1'b0;
        rom_addr    <= '0;
        tag_pipe[0] <= WS_BG;
        // accept and apply are exclusive: accept needs an empty slot
        cfg_pending <= accept;
        if (cfg_pending) begin
          if (pend_win) begin
            x1_q <= pend_x;
            y1_q <= pend_y;
          end else begin
            x0_q <= pend_x;
            y0_q <= pend_y;
          end
        end
      end else begin
        cfg_pending <= cfg_pending | accept;
        if (state == RUN) begin
          if (hit0) cnt0 <= next_cnt(cnt0);
          if (hit1) cnt1 <= next_cnt(cnt1);
          rom_en      <= hit0 | hit1;
          rom_addr    <= hit0 ? cnt0 : (hit1 ? cnt1 : '0);
          tag_pipe[0] <= tag_in;
        end else begin
          rom_en      <= 1'b0;
          rom_addr    <= '0;
          tag_pipe[0] <= WS_BG;
        end
      end
    end
  end

endmodule
